// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared aluop codes, FSM states and access-size decode for mem_stage_lsu
package lsu_pkg;

  localparam logic [7:0] LD_B  = 8'h20;
  localparam logic [7:0] LD_H  = 8'h21;
  localparam logic [7:0] LD_W  = 8'h23;
  localparam logic [7:0] LD_BU = 8'h24;
  localparam logic [7:0] LD_HU = 8'h25;
  localparam logic [7:0] ST_B  = 8'h28;
  localparam logic [7:0] ST_H  = 8'h29;
  localparam logic [7:0] ST_W  = 8'h2B;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_OUT, S_DRAIN} lsu_state_e;

  typedef struct packed {
    logic      is_mem;
    logic      is_load;
    mem_size_e size;
    logic      sign;
  } mem_op_t;

  // Anything not listed is a non-memory op and passes straight through.
  function automatic mem_op_t decode_op(input logic [7:0] op);
    mem_op_t d;
    d = '{1'b0, 1'b0, SZ_W, 1'b0};
    case (op)
      LD_B:    d = '{1'b1, 1'b1, SZ_B, 1'b1};
      LD_H:    d = '{1'b1, 1'b1, SZ_H, 1'b1};
      LD_W:    d = '{1'b1, 1'b1, SZ_W, 1'b0};
      LD_BU:   d = '{1'b1, 1'b1, SZ_B, 1'b0};
      LD_HU:   d = '{1'b1, 1'b1, SZ_H, 1'b0};
      ST_B:    d = '{1'b1, 1'b0, SZ_B, 1'b0};
      ST_H:    d = '{1'b1, 1'b0, SZ_H, 1'b0};
      ST_W:    d = '{1'b1, 1'b0, SZ_W, 1'b0};
      default: d = '{1'b0, 1'b0, SZ_W, 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/half of a load word and extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  mem_size_e   i_size,
  input  logic        i_sign,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = i_rdata;
    case (i_size)
      SZ_B:    o_data = {{24{i_sign & w_byte[7]}}, w_byte};
      SZ_H:    o_data = {{16{i_sign & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-access stage: data-bus request FSM feeding a registered WB slot
// Optional MEM_ALIGN_CHECK_EN: misaligned H/W accesses skip the bus and raise wb_excp_o.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [ALUOP_W-1:0]    ex_aluop_i,
  input  logic [ADDR_W-1:0]     ex_mem_addr_i,
  input  logic [DATA_W-1:0]     ex_reg2_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  ex_wreg_i,
  input  logic [DATA_W-1:0]     ex_wdata_i,
  input  logic [ADDR_W-1:0]     ex_pc_i,
  output logic                  data_req_o,
  output logic                  data_we_o,
  output logic [ADDR_W-1:0]     data_addr_o,
  output logic [3:0]            data_be_o,
  output logic [DATA_W-1:0]     data_wdata_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  input  logic [DATA_W-1:0]     data_rdata_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [REG_ADDR_W-1:0] wb_wd_o,
  output logic                  wb_wreg_o,
  output logic [DATA_W-1:0]     wb_wdata_o,
  output logic [ADDR_W-1:0]     wb_pc_o,
  output logic                  wb_excp_o
);

  lsu_state_e            r_state;
  logic                  r_is_load, r_sign, r_wreg, r_excp;
  mem_size_e             r_size;
  logic [ADDR_W-1:0]     r_addr, r_pc;
  logic [DATA_W-1:0]     r_reg2, r_res;
  logic [REG_ADDR_W-1:0] r_wd;

  logic                  r_wb_valid, r_wb_wreg, r_wb_excp;
  logic [REG_ADDR_W-1:0] r_wb_wd;
  logic [DATA_W-1:0]     r_wb_wdata;
  logic [ADDR_W-1:0]     r_wb_pc;

  mem_op_t               w_dec;
  logic                  w_slot_free, w_accept, w_misalign, w_req;
  logic [3:0]            w_be;
  logic [DATA_W-1:0]     w_st_data, w_load_data;
  logic                  w_wb_load, w_wb_wreg, w_wb_excp;
  logic [REG_ADDR_W-1:0] w_wb_wd;
  logic [DATA_W-1:0]     w_wb_wdata;
  logic [ADDR_W-1:0]     w_wb_pc;

  assign w_dec       = decode_op(8'(ex_aluop_i));
  assign w_slot_free = !r_wb_valid || wb_ready_i;
  // Reset also forces ready low so every output reads 0 while rst is asserted.
  assign ex_ready_o  = rst && (r_state == S_IDLE) && w_slot_free;
  assign w_accept    = ex_valid_i && ex_ready_o && !flush_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_dec.is_mem &&
                      (((w_dec.size == SZ_H) && ex_mem_addr_i[0]) ||
                       ((w_dec.size == SZ_W) && (ex_mem_addr_i[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_be      = 4'b1111;
    w_st_data = r_reg2;
    case (r_size)
      SZ_B: begin
        w_be      = 4'b0001 << r_addr[1:0];
        w_st_data = {4{r_reg2[7:0]}};
      end
      SZ_H: begin
        w_be      = 4'b0011 << {r_addr[1], 1'b0};
        w_st_data = {2{r_reg2[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_req        = (r_state == S_REQ);
  assign data_req_o   = w_req;
  assign data_we_o    = w_req && !r_is_load;
  assign data_addr_o  = w_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign data_be_o    = w_req ? w_be : 4'b0000;
  assign data_wdata_o = w_req ? w_st_data : '0;

  lsu_load_align u_align (
    .i_rdata   (data_rdata_i),
    .i_addr_lo (r_addr[1:0]),
    .i_size    (r_size),
    .i_sign    (r_sign),
    .o_data    (w_load_data)
  );

  // Results bypass OUT and land in the WB slot directly whenever it is free.
  always_comb begin
    w_wb_load  = 1'b0;
    w_wb_wd    = r_wd;
    w_wb_wreg  = r_wreg;
    w_wb_wdata = r_res;
    w_wb_pc    = r_pc;
    w_wb_excp  = r_excp;
    if (!flush_i) begin
      case (r_state)
        S_IDLE: if (w_accept && !w_dec.is_mem) begin
          w_wb_load  = 1'b1;
          w_wb_wd    = ex_wd_i;
          w_wb_wreg  = ex_wreg_i;
          w_wb_wdata = ex_wdata_i;
          w_wb_pc    = ex_pc_i;
          w_wb_excp  = 1'b0;
        end
        S_REQ:  w_wb_load = data_gnt_i && !r_is_load && w_slot_free;
        S_RESP: if (data_rvalid_i && w_slot_free) begin
          w_wb_load  = 1'b1;
          w_wb_wdata = w_load_data;
        end
        S_OUT:  w_wb_load = w_slot_free;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_is_load <= 1'b0;
      r_size    <= SZ_W;
      r_sign    <= 1'b0;
      r_addr    <= '0;
      r_reg2    <= '0;
      r_wd      <= '0;
      r_wreg    <= 1'b0;
      r_pc      <= '0;
      r_res     <= '0;
      r_excp    <= 1'b0;
    end else if (flush_i) begin
      // A load already granted still owes an rvalid; swallow it in DRAIN.
      case (r_state)
        S_REQ:   r_state <= (data_gnt_i && r_is_load) ? S_DRAIN : S_IDLE;
        S_RESP:  r_state <= data_rvalid_i ? S_IDLE : S_DRAIN;
        S_DRAIN: r_state <= data_rvalid_i ? S_IDLE : S_DRAIN;
        default: r_state <= S_IDLE;
      endcase
    end else begin
      case (r_state)
        S_IDLE: if (w_accept && w_dec.is_mem) begin
          r_is_load <= w_dec.is_load;
          r_size    <= w_dec.size;
          r_sign    <= w_dec.sign;
          r_addr    <= ex_mem_addr_i;
          r_reg2    <= ex_reg2_i;
          r_wd      <= ex_wd_i;
          r_pc      <= ex_pc_i;
          r_wreg    <= w_dec.is_load && !w_misalign && ex_wreg_i;
          r_res     <= w_misalign ? DATA_W'(ex_mem_addr_i) : '0;
          r_excp    <= w_misalign;
          r_state   <= w_misalign ? S_OUT : S_REQ;
        end
        S_REQ: if (data_gnt_i) begin
          r_state <= r_is_load ? S_RESP : (w_slot_free ? S_IDLE : S_OUT);
        end
        S_RESP: if (data_rvalid_i) begin
          r_res   <= w_load_data;
          r_state <= w_slot_free ? S_IDLE : S_OUT;
        end
        S_OUT:   if (w_slot_free) r_state <= S_IDLE;
        S_DRAIN: if (data_rvalid_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid <= 1'b0;
      r_wb_wd    <= '0;
      r_wb_wreg  <= 1'b0;
      r_wb_wdata <= '0;
      r_wb_pc    <= '0;
      r_wb_excp  <= 1'b0;
    end else if (flush_i) begin
      r_wb_valid <= 1'b0;
    end else if (w_wb_load) begin
      r_wb_valid <= 1'b1;
      r_wb_wd    <= w_wb_wd;
      r_wb_wreg  <= w_wb_wreg;
      r_wb_wdata <= w_wb_wdata;
      r_wb_pc    <= w_wb_pc;
      r_wb_excp  <= w_wb_excp;
    end else if (wb_ready_i) begin
      r_wb_valid <= 1'b0;
    end
  end

  assign wb_valid_o = r_wb_valid;
  assign wb_wd_o    = r_wb_wd;
  assign wb_wreg_o  = r_wb_wreg;
  assign wb_wdata_o = r_wb_wdata;
  assign wb_pc_o    = r_wb_pc;
  // Stays 0 in builds without the alignment check.
  assign wb_excp_o  = r_wb_excp;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - directed plus randomized bench for mem_stage_lsu with a transaction-level model
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i, ex_valid_i, ex_ready_o, ex_wreg_i;
  logic [7:0]  ex_aluop_i;
  logic [31:0] ex_mem_addr_i, ex_reg2_i, ex_wdata_i, ex_pc_i;
  logic [4:0]  ex_wd_i;
  logic        data_req_o, data_we_o, data_gnt_i, data_rvalid_i;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;
  logic        wb_valid_o, wb_ready_i, wb_wreg_o, wb_excp_o;
  logic [4:0]  wb_wd_o;
  logic [31:0] wb_wdata_o, wb_pc_o;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] op_tbl [10];

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_aluop_i(ex_aluop_i),
    .ex_mem_addr_i(ex_mem_addr_i), .ex_reg2_i(ex_reg2_i), .ex_wd_i(ex_wd_i),
    .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i), .ex_pc_i(ex_pc_i),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_wd_o(wb_wd_o),
    .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o), .wb_pc_o(wb_pc_o),
    .wb_excp_o(wb_excp_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the access rules: lane offset, enables, replication, extension.
  function automatic void model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                input logic [31:0] rdata, output bit is_mem, output bit is_load,
                                output bit misal, output logic [3:0] be, output logic [31:0] bw,
                                output logic [31:0] ld);
    int sz, sh;
    bit sgn;
    logic [31:0] mask, v;
    is_mem = 1; is_load = 1; sgn = 0; sz = 4;
    case (op)
      LD_B:  begin sz = 1; sgn = 1; end
      LD_BU: sz = 1;
      LD_H:  begin sz = 2; sgn = 1; end
      LD_HU: sz = 2;
      LD_W:  sz = 4;
      ST_B:  begin sz = 1; is_load = 0; end
      ST_H:  begin sz = 2; is_load = 0; end
      ST_W:  is_load = 0;
      default: begin is_mem = 0; is_load = 0; end
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    misal = is_mem && ((int'(addr % 4) % sz) != 0);
`else
    misal = 0;
`endif
    sh   = (sz == 4) ? 0 : (int'(addr % 4) / sz) * sz;
    be   = 4'(((1 << sz) - 1) << sh);
    mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * sz)) - 1);
    bw   = (sz == 1) ? (reg2 & mask) * 32'h0101_0101 :
           (sz == 2) ? (reg2 & mask) * 32'h0001_0001 : reg2;
    v    = (rdata >> (8 * sh)) & mask;
    if (sgn && v[8 * sz - 1]) v = v | ~mask;
    ld   = v;
  endfunction

  // Called and returns on a negedge; gd = cycles of req before gnt, rd = cycles from gnt to rvalid.
  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                       input logic [31:0] rdata, input int gd, input int rd, input int stall,
                       input bit rv_junk);
    bit is_mem, is_load, misal;
    logic [3:0] be;
    logic [31:0] bw, ld, pc, exw, e_wdata;
    logic [4:0] wd;
    logic wreg_in, e_wreg;
    int acc, n, e_lat;
    wd = 5'($urandom); pc = $urandom; exw = $urandom; wreg_in = 1'($urandom);
    model(op, addr, reg2, rdata, is_mem, is_load, misal, be, bw, ld);
    if (!is_mem) begin e_wdata = exw; e_wreg = wreg_in; e_lat = 0; end
    else if (misal) begin e_wdata = addr; e_wreg = 0; e_lat = 1; end
    else if (is_load) begin e_wdata = ld; e_wreg = wreg_in; e_lat = 1 + gd + rd; end
    else begin e_wdata = 0; e_wreg = 0; e_lat = 1 + gd; end

    ex_valid_i = 1; ex_aluop_i = op; ex_mem_addr_i = addr; ex_reg2_i = reg2;
    ex_wd_i = wd; ex_wreg_i = wreg_in; ex_wdata_i = exw; ex_pc_i = pc; wb_ready_i = 1;
    #1 chk("ex_ready_before_accept", ex_ready_o, 1);
    @(posedge clk); #1;
    acc = cyc;
    ex_valid_i = 0; ex_mem_addr_i = $urandom; ex_reg2_i = $urandom; ex_aluop_i = 8'h01;

    if (is_mem && !misal) begin
      for (int i = 0; i <= gd; i++) begin
        @(negedge clk);
        data_gnt_i = (i == gd);
        if (i == gd && is_load && rv_junk) begin data_rvalid_i = 1; data_rdata_i = ~rdata; end
        chk("bus_req", data_req_o, 1);
        chk("bus_we", data_we_o, !is_load);
        chk("bus_addr", data_addr_o, addr & 32'hFFFF_FFFC);
        chk("bus_be", data_be_o, be);
        if (!is_load) chk("bus_wdata", data_wdata_o, bw);
        @(posedge clk); #1;
        data_gnt_i = 0; data_rvalid_i = 0;
      end
      if (is_load) begin
        for (int i = 1; i <= rd; i++) begin
          @(negedge clk);
          chk("req_released", data_req_o, 0);
          if (i == rd) begin data_rvalid_i = 1; data_rdata_i = rdata; end
          @(posedge clk); #1;
          data_rvalid_i = 0; data_rdata_i = $urandom;
        end
      end
    end

    n = 0;
    @(negedge clk);
    if (misal) chk("misaligned_no_req", data_req_o, 0);
    while (!wb_valid_o && n < 10) begin n++; @(negedge clk); end
    chk("wb_valid", wb_valid_o, 1);
    chk("wb_latency", cyc - acc, e_lat);
    for (int s = 0; s <= stall; s++) begin
      wb_ready_i = (s == stall);
      #1;
      chk("wb_valid_held", wb_valid_o, 1);
      chk("wb_wd", wb_wd_o, wd);
      chk("wb_wreg", wb_wreg_o, e_wreg);
      chk("wb_wdata", wb_wdata_o, e_wdata);
      chk("wb_pc", wb_pc_o, pc);
      chk("wb_excp", wb_excp_o, misal);
      chk("ex_ready_vs_stall", ex_ready_o, (s == stall));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("wb_drained", wb_valid_o, 0);
  endtask

  initial begin
    op_tbl = '{LD_B, LD_H, LD_W, LD_BU, LD_HU, ST_B, ST_H, ST_W, 8'h01, 8'hFF};
    rst = 0; flush_i = 0; ex_valid_i = 0; ex_aluop_i = 0; ex_mem_addr_i = 0; ex_reg2_i = 0;
    ex_wd_i = 0; ex_wreg_i = 0; ex_wdata_i = 0; ex_pc_i = 0; data_gnt_i = 0;
    data_rvalid_i = 0; data_rdata_i = 0; wb_ready_i = 1;
    #12;
    chk("reset_ex_ready", ex_ready_o, 0);
    chk("reset_req", data_req_o, 0);
    chk("reset_wb_valid", wb_valid_o, 0);
    chk("reset_wb_wdata", wb_wdata_o, 0);
    chk("reset_wb_excp", wb_excp_o, 0);
    @(negedge clk); rst = 1;
    #1 chk("post_reset_ex_ready", ex_ready_o, 1);
    @(negedge clk);

    do_op(ST_B, 32'h1003, 32'h0000_00AB, 32'h0, 0, 1, 0, 0);
    do_op(LD_B, 32'h2001, 32'h0, 32'h0000_8000, 3, 1, 0, 1);
    do_op(LD_BU, 32'h2001, 32'h0, 32'h0000_8000, 0, 1, 0, 0);
    do_op(LD_HU, 32'h2002, 32'h0, 32'hBEEF_1234, 0, 2, 0, 0);
    do_op(LD_W, 32'h2000, 32'h0, 32'hBEEF_1234, 1, 1, 0, 0);
    do_op(8'h01, 32'h0, 32'h0, 32'h0, 0, 1, 2, 0);
    do_op(LD_W, 32'h3002, 32'h0, 32'hCAFE_F00D, 0, 1, 0, 0);

    // Flush while waiting for load data; the late rvalid must be swallowed.
    ex_valid_i = 1; ex_aluop_i = LD_W; ex_mem_addr_i = 32'h40;
    @(posedge clk); #1 ex_valid_i = 0;
    @(negedge clk); data_gnt_i = 1;
    chk("flush_resp_req", data_req_o, 1);
    @(posedge clk); #1 data_gnt_i = 0;
    @(negedge clk); flush_i = 1;
    chk("flush_resp_ready_low", ex_ready_o, 0);
    @(posedge clk); #1 flush_i = 0;
    @(negedge clk);
    chk("drain_ready_low", ex_ready_o, 0);
    chk("drain_no_wb", wb_valid_o, 0);
    chk("drain_no_req", data_req_o, 0);
    @(posedge clk); #1;
    @(negedge clk); data_rvalid_i = 1; data_rdata_i = 32'h1234_5678;
    chk("drain_rvalid_ready_low", ex_ready_o, 0);
    @(posedge clk); #1 data_rvalid_i = 0;
    @(negedge clk);
    chk("drain_done_ready", ex_ready_o, 1);
    chk("drain_done_no_wb", wb_valid_o, 0);

    // Flush during an ungranted request drops it.
    ex_valid_i = 1; ex_aluop_i = ST_W; ex_mem_addr_i = 32'h80;
    @(posedge clk); #1 ex_valid_i = 0;
    @(negedge clk); flush_i = 1;
    chk("flush_req_pending", data_req_o, 1);
    @(posedge clk); #1 flush_i = 0;
    @(negedge clk);
    chk("flush_req_dropped", data_req_o, 0);
    chk("flush_req_ready", ex_ready_o, 1);
    chk("flush_req_no_wb", wb_valid_o, 0);

    // Flush clears a stalled WB slot.
    ex_valid_i = 1; ex_aluop_i = 8'h01; ex_wdata_i = 32'h5555_AAAA;
    @(posedge clk); #1 ex_valid_i = 0;
    @(negedge clk); wb_ready_i = 0;
    chk("slot_filled", wb_valid_o, 1);
    flush_i = 1;
    @(posedge clk); #1 flush_i = 0; wb_ready_i = 1;
    @(negedge clk);
    chk("flush_clears_slot", wb_valid_o, 0);

    for (int k = 0; k < 40; k++) begin
      do_op(op_tbl[$urandom_range(0, 9)], $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2),
            1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
